// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - op codes and per-bit function of the buffered logic unit
package logic_unit_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_OR   = 3'd1;
    localparam op_t OP_NAND = 3'd2;
    localparam op_t OP_NOR  = 3'd3;
    localparam op_t OP_XOR  = 3'd4;
    localparam op_t OP_XNOR = 3'd5;
    localparam op_t OP_NOT  = 3'd6;
    localparam op_t OP_PASS = 3'd7;

    // Every op is bitwise, so one bit-slice function covers any width.
    function automatic logic lu_bit(input logic a, input logic b, input op_t op);
        logic y;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            default: y = a;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/logic_op_comb.sv
// rtl/logic_op_comb.sv - combinational WIDTH-wide op decoder
module logic_op_comb
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_y
);

    always_comb begin
        o_y = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_y[i] = lu_bit(i_a[i], i_b[i], i_op);
        end
    end

endmodule

// File: rtl/logic_unit_buffered.sv
// rtl/logic_unit_buffered.sv - op-selectable logic unit with result FIFO and pop counter
module logic_unit_buffered
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_done_cnt;

    logic [WIDTH-1:0] w_op_y;
    logic [WIDTH-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    logic_op_comb #(.WIDTH(WIDTH)) u_op (
        .i_a  (in_a),
        .i_b  (in_b),
        .i_op (in_op),
        .o_y  (w_op_y)
    );

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = out_ready && !w_empty;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_op_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_cnt <= '0;
        end else if (w_pop && (r_done_cnt != {CNT_W{1'b1}})) begin
            r_done_cnt <= r_done_cnt + 1'b1;
        end
    end

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_y     = w_empty ? '0 : w_head;
    assign out_zero  = !w_empty && (w_head == '0);
    assign out_ones  = !w_empty && (&w_head);
    assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_logic_unit_buffered.sv
// tb/tb_logic_unit_buffered.sv - scoreboard bench for logic_unit_buffered
module tb_logic_unit_buffered;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_op;
    logic       out_ready;

    logic       in_ready,  in_ready_s;
    logic       out_valid, out_valid_s;
    logic [3:0] out_y,     out_y_s;
    logic       out_zero,  out_zero_s;
    logic       out_ones,  out_ones_s;
    logic [7:0] done_cnt;
    logic [2:0] done_cnt_s;

    int total = 0;
    int bad   = 0;
    int cnt   = 0;
    logic [3:0] q[$];
    logic [3:0] sweep_exp [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                                  4'b0110, 4'b1001, 4'b0011, 4'b1100};

    always #5 clk = ~clk;

    logic_unit_buffered #(.WIDTH(4), .DEPTH(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero),
        .out_ones(out_ones), .done_cnt(done_cnt)
    );

    logic_unit_buffered #(.WIDTH(4), .DEPTH(2), .CNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_y(out_y_s), .out_zero(out_zero_s),
        .out_ones(out_ones_s), .done_cnt(done_cnt_s)
    );

    function automatic logic [3:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        logic [3:0] head;
        int         sat;
        head = (q.size() != 0) ? q[0] : 4'b0000;
        sat  = (cnt > 7) ? 7 : cnt;
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready",  32'(in_ready),  32'(q.size() < 2));
        chk("out_y",     32'(out_y),     32'(head));
        chk("out_zero",  32'(out_zero),  32'((q.size() != 0) && (head == 4'b0000)));
        chk("out_ones",  32'(out_ones),  32'((q.size() != 0) && (head == 4'b1111)));
        chk("done_cnt",  32'(done_cnt),  32'((cnt > 255) ? 255 : cnt));
        chk("done_sat",  32'(done_cnt_s), 32'(sat));
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op);
        in_valid = v;
        in_a     = v ? a  : 4'bxxxx;
        in_b     = v ? b  : 4'bxxxx;
        in_op    = v ? op : 3'bxxx;
    endtask

    task automatic cycle();
        logic       push;
        logic       pop;
        logic [3:0] res;
        push = in_valid && (q.size() < 2);
        pop  = out_ready && (q.size() != 0);
        res  = model(in_a, in_b, in_op);
        @(posedge clk);
        if (pop) begin
            void'(q.pop_front());
            cnt++;
        end
        if (push) begin
            q.push_back(res);
        end
        #1;
        check_state();
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 4'b0, 4'b0, 3'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state();

        // NAND directed beats
        out_ready = 1'b1;
        drive(1'b1, 4'b0010, 4'b0110, 3'd2);
        cycle();
        chk("nand_a", 32'(out_y), 32'(4'b1101));
        drive(1'b1, 4'b0111, 4'b0100, 3'd2);
        cycle();
        chk("nand_b", 32'(out_y), 32'(4'b1011));
        drive(1'b1, 4'b0000, 4'b1110, 3'd2);
        cycle();
        chk("nand_c", 32'(out_y), 32'(4'b1111));
        chk("nand_c_ones", 32'(out_ones), 32'(1'b1));
        drive(1'b0, 4'b0, 4'b0, 3'd0);
        cycle();

        // op sweep, one result per cycle
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 4'b1100, 4'b1010, 3'(k));
            cycle();
            chk($sformatf("sweep_op%0d", k), 32'(out_y), 32'(sweep_exp[k]));
        end
        drive(1'b0, 4'b0, 4'b0, 3'd0);
        cycle();
        chk("sweep_cnt", 32'(done_cnt), 32'd11);
        chk("sweep_sat", 32'(done_cnt_s), 32'd7);

        // backpressure into a full FIFO
        out_ready = 1'b0;
        drive(1'b1, 4'b0011, 4'b0101, 3'd4);
        cycle();
        drive(1'b1, 4'b0011, 4'b0101, 3'd0);
        cycle();
        chk("bp_full", 32'(in_ready), 32'(1'b0));
        drive(1'b1, 4'b0011, 4'b0101, 3'd1);
        cycle();
        chk("bp_hold1", 32'(out_y), 32'(4'b0110));
        cycle();
        chk("bp_hold2", 32'(out_y), 32'(4'b0110));
        out_ready = 1'b1;
        cycle();
        chk("bp_rise", 32'(in_ready), 32'(1'b1));
        cycle();
        drive(1'b0, 4'b0, 4'b0, 3'd0);
        cycle();
        chk("bp_third", 32'(out_y), 32'(4'b0000));
        cycle();

        // simultaneous push and pop with one entry queued
        out_ready = 1'b0;
        drive(1'b1, 4'b1001, 4'b0000, 3'd7);
        cycle();
        out_ready = 1'b1;
        drive(1'b1, 4'b0101, 4'b0011, 3'd3);
        cycle();
        chk("pp_valid", 32'(out_valid), 32'(1'b1));
        chk("pp_ready", 32'(in_ready), 32'(1'b1));
        chk("pp_head",  32'(out_y), 32'(4'b1000));
        out_ready = 1'b0;
        drive(1'b1, 4'b1111, 4'b0000, 3'd6);
        cycle();
        drive(1'b0, 4'b0, 4'b0, 3'd0);
        chk("pp_full", 32'(in_ready), 32'(1'b0));

        // asynchronous reset with two entries queued
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'(1'b0));
        chk("rst_y",     32'(out_y), 32'(4'b0000));
        chk("rst_cnt",   32'(done_cnt), 32'd0);
        chk("rst_cnt_s", 32'(done_cnt_s), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'(1'b1));
        q.delete();
        cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state();

        // saturation of the narrow counter, then an all-zero PASS
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 4'(i), ~4'(i), 3'(i % 8));
            cycle();
        end
        drive(1'b1, 4'b0000, 4'b1111, 3'd7);
        cycle();
        chk("pass_zero", 32'(out_zero), 32'(1'b1));
        drive(1'b0, 4'b0, 4'b0, 3'd0);
        cycle();
        chk("sat_7",  32'(done_cnt_s), 32'd7);
        chk("cnt_10", 32'(done_cnt), 32'd10);
        cycle();
        chk("empty_pop", 32'(done_cnt), 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
